block_lock_ctrl: RTL
====================

// Module: block_lock_ctrl
// PURPOSE
//  64b/66b block-lock controller between the RX gearbox and decoder64b66b.
//  Checks the 2-bit sync header of every 66-bit block and counts valid and invalid headers.
//  Drives a slip pulse to the gearbox until block alignment is found.
//  Forwards blocks to the decoder only while block_lock=1 (IEEE 802.3 cl.49 lock FSM).
// PARAMETERS
//  LOCK_CNT     64     consecutive valid headers needed to declare lock
//  WINDOW_CNT   1024   header window while locked; counters restart at window end
//  INVALID_MAX  16     invalid headers inside one window that force loss of lock
//  SLIP_WAIT    4      idle cycles after slip, giving the gearbox time to realign
//  HIBER_WINDOW 19531  blocks per hi-BER window (125 us at 156.25 MHz)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous reset, active-high
//  s_axis_tdata   in   66  block from gearbox; [65:64] = sync header
//  s_axis_tvalid  in   1   block valid
//  s_axis_tready  out  1   block accepted
//  m_axis_tdata   out  66  block to decoder
//  m_axis_tvalid  out  1   output valid
//  m_axis_tready  in   1   decoder ready
//  slip           out  1   1-cycle pulse: gearbox shifts alignment by 1 bit
//  block_lock     out  1   alignment status
//  hi_ber         out  1   high bit-error-rate flag
// BEHAVIOUR
//  Reset values: m_axis_tvalid=0, slip=0, block_lock=0, hi_ber=0, FSM=RESET_CNT, all counters 0.
//  Header check: sh_valid = ^s_axis_tdata[65:64] (01 or 10 valid; 00 and 11 invalid).
//  Counted event: s_axis_tvalid & s_axis_tready; exactly one header checked per accepted block.
//  Output stage: 1 register stage, latency 1 cycle.
//   - s_axis_tready = !m_axis_tvalid | m_axis_tready, except in SLIP_HOLD where it is 1.
//   - Accepted blocks load m_axis_tdata and set m_axis_tvalid = block_lock (the value before the update).
//   - While unlocked, blocks are consumed and dropped.
//  FSM states:
//   RESET_CNT: clear sh_cnt and inv_cnt -> TEST_SH.
//   TEST_SH, on each accepted block: sh_cnt++; if !sh_valid, inv_cnt++.
//    - Unlocked and invalid header -> SLIP.
//    - Unlocked and sh_cnt hits LOCK_CNT with inv_cnt=0 -> block_lock<=1, go to RESET_CNT.
//    - Locked and inv_cnt hits INVALID_MAX -> block_lock<=0, go to SLIP.
//    - Locked and sh_cnt hits WINDOW_CNT with inv_cnt<INVALID_MAX -> RESET_CNT.
//   SLIP: slip=1 for exactly 1 cycle -> SLIP_HOLD.
//   SLIP_HOLD: drop input blocks for SLIP_WAIT cycles -> RESET_CNT.
//  Simultaneous events: INVALID_MAX reached on the last block of a window -> SLIP wins.
//  Loss of lock: output registers not yet taken by the decoder remain valid and drain normally.
//  Counter widths: $clog2(WINDOW_CNT+1); counters saturate and never wrap.
//  Reset mid-operation: aborts any slip/hold; output register is invalidated the same cycle.
// CONFIGURATION
//  BLOCK_LOCK_HIBER_EN defined:
//   - hi_ber monitor counts invalid headers over each HIBER_WINDOW accepted blocks.
//   - hi_ber=1 when the count reaches 16 within a window.
//   - The flag is re-evaluated at every window end: set if >=16, else cleared.
//   - While hi_ber=1, m_axis_tvalid is suppressed (blocks dropped).
//  BLOCK_LOCK_HIBER_EN undefined: hi_ber tied 0; no monitor logic.
// STRUCTURE
//  Package pcs64b66b_pkg:
//   - lock_state_t enum {RESET_CNT, TEST_SH, SLIP, SLIP_HOLD}
//   - SH_DATA=2'b01, SH_CTRL=2'b10, BLOCK_W=66
//  Sub-module hi_ber_mon, instantiated only under BLOCK_LOCK_HIBER_EN:
//   - inputs: clk, reset, hdr_strobe, hdr_invalid
//   - output: hi_ber
// TESTING
//  1. Reset, then 64 blocks with SH=01, m_axis_tready=1:
//     - block_lock=1 after the 64th block; 0 blocks forwarded before it.
//     - Block 65 appears on m_axis 1 cycle after acceptance.
//  2. Unlocked, block 10 has SH=00:
//     - slip pulses for 1 cycle.
//     - s_axis_tready=1 and 4 dropped cycles in hold, then counting restarts from 0.
//  3. Locked, 16 invalid headers within 1024 blocks:
//     - block_lock falls on the 16th invalid block; slip=1 next cycle.
//     - With only 15 invalid headers, lock is held and the window restarts at block 1024.
//  4. Locked, m_axis_tready held 0 for 5 cycles:
//     - s_axis_tready=0, no block lost or duplicated; data order preserved.
//     - Counters advance only on accepted blocks.
//  5. reset asserted for 1 cycle during SLIP_HOLD:
//     - All outputs return to reset values on the next edge; FSM=RESET_CNT.
//  6. BLOCK_LOCK_HIBER_EN, locked, 16 invalid headers spread over 19531 blocks with <16 per 1024-block lock window:
//     - hi_ber=1 and output suppressed.
//     - Next window with 0 invalid headers -> hi_ber=0.

Source files
------------

// File: rtl/pcs64b66b_pkg.sv
// Shared 64b/66b PCS constants and the block-lock FSM state type.
// The optional hi-BER window constants are consumed only when BLOCK_LOCK_HIBER_EN is defined.
package pcs64b66b_pkg;

    localparam int BLOCK_W = 66;
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int HIBER_WINDOW = 19531;
    localparam int HIBER_LIMIT  = 16;

    typedef enum logic [1:0] {
        RESET_CNT = 2'd0,
        TEST_SH   = 2'd1,
        SLIP      = 2'd2,
        SLIP_HOLD = 2'd3
    } lock_state_t;

    // Only the two transition patterns are legal sync headers.
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/block_lock_ctrl_hi_ber_mon.sv
// Hi-BER monitor: counts invalid sync headers over fixed windows of checked blocks.
// Present only when BLOCK_LOCK_HIBER_EN is defined.
`ifdef BLOCK_LOCK_HIBER_EN
module hi_ber_mon
    import pcs64b66b_pkg::*;
#(
    parameter int WINDOW = HIBER_WINDOW,
    parameter int LIMIT  = HIBER_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic hdr_strobe,
    input  logic hdr_invalid,
    output logic hi_ber
);

    localparam int BLK_W = $clog2(WINDOW + 1);
    localparam int INV_W = $clog2(LIMIT + 1);

    logic [BLK_W-1:0] blk_cnt_reg;
    logic [INV_W-1:0] inv_cnt_reg;
    logic [INV_W-1:0] inv_cnt_next;
    logic             hi_ber_reg;

    // Saturate at the limit; anything beyond it carries no extra information.
    assign inv_cnt_next = (hdr_invalid && (inv_cnt_reg != INV_W'(LIMIT)))
                        ? inv_cnt_reg + INV_W'(1) : inv_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt_reg <= '0;
            inv_cnt_reg <= '0;
            hi_ber_reg  <= 1'b0;
        end else if (hdr_strobe) begin
            if (blk_cnt_reg == BLK_W'(WINDOW - 1)) begin
                blk_cnt_reg <= '0;
                inv_cnt_reg <= '0;
                hi_ber_reg  <= (inv_cnt_next == INV_W'(LIMIT));
            end else begin
                blk_cnt_reg <= blk_cnt_reg + BLK_W'(1);
                inv_cnt_reg <= inv_cnt_next;
                if (inv_cnt_next == INV_W'(LIMIT)) begin
                    hi_ber_reg <= 1'b1;
                end
            end
        end
    end

    assign hi_ber = hi_ber_reg;

endmodule
`endif

// File: rtl/block_lock_ctrl.sv
// 64b/66b block-lock controller: sync-header checking, slip generation and gated forwarding.
// Define BLOCK_LOCK_HIBER_EN to add the hi-BER monitor and output suppression.
module block_lock_ctrl
    import pcs64b66b_pkg::*;
#(
    parameter int LOCK_CNT    = 64,
    parameter int WINDOW_CNT  = 1024,
    parameter int INVALID_MAX = 16,
    parameter int SLIP_WAIT   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic [BLOCK_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               slip,
    output logic               block_lock,
    output logic               hi_ber
);

    localparam int CNT_W  = $clog2(WINDOW_CNT + 1);
    localparam int HOLD_W = $clog2(SLIP_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    lock_state_t       state_reg, state_next;
    logic [CNT_W-1:0]  sh_cnt_reg, sh_cnt_next;
    logic [CNT_W-1:0]  inv_cnt_reg, inv_cnt_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              block_lock_reg, block_lock_next;
    logic [BLOCK_W-1:0] out_data_reg;
    logic              out_valid_reg;

    logic              accept;
    logic              checking;
    logic              sh_valid;
    logic [CNT_W-1:0]  sh_base, inv_base, sh_inc, inv_inc;

    assign s_axis_tready = (state_reg == SLIP_HOLD) ? 1'b1 : (!out_valid_reg || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    // A block taken in RESET_CNT is checked as the first block of the fresh count.
    assign checking      = accept && ((state_reg == RESET_CNT) || (state_reg == TEST_SH));
    assign sh_valid      = sh_is_valid(s_axis_tdata[BLOCK_W-1 -: 2]);

    assign sh_base  = (state_reg == RESET_CNT) ? '0 : sh_cnt_reg;
    assign inv_base = (state_reg == RESET_CNT) ? '0 : inv_cnt_reg;
    assign sh_inc   = (sh_base == CNT_MAX) ? sh_base : sh_base + CNT_W'(1);
    assign inv_inc  = (!sh_valid && (inv_base != CNT_MAX)) ? inv_base + CNT_W'(1) : inv_base;

    always_comb begin
        state_next      = state_reg;
        sh_cnt_next     = sh_cnt_reg;
        inv_cnt_next    = inv_cnt_reg;
        hold_cnt_next   = hold_cnt_reg;
        block_lock_next = block_lock_reg;

        case (state_reg)
            RESET_CNT: begin
                sh_cnt_next  = '0;
                inv_cnt_next = '0;
                state_next   = TEST_SH;
            end
            SLIP: begin
                hold_cnt_next = '0;
                state_next    = SLIP_HOLD;
            end
            SLIP_HOLD: begin
                if (hold_cnt_reg == HOLD_W'(SLIP_WAIT - 1)) begin
                    state_next = RESET_CNT;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            default: ;
        endcase

        if (checking) begin
            sh_cnt_next  = sh_inc;
            inv_cnt_next = inv_inc;
            state_next   = TEST_SH;
            if (!block_lock_reg) begin
                if (!sh_valid) begin
                    state_next = SLIP;
                end else if ((sh_inc == CNT_W'(LOCK_CNT)) && (inv_inc == '0)) begin
                    block_lock_next = 1'b1;
                    state_next      = RESET_CNT;
                end
            end else begin
                // Loss of lock is tested first so it wins on the last block of a window.
                if (inv_inc >= CNT_W'(INVALID_MAX)) begin
                    block_lock_next = 1'b0;
                    state_next      = SLIP;
                end else if (sh_inc == CNT_W'(WINDOW_CNT)) begin
                    state_next = RESET_CNT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RESET_CNT;
            sh_cnt_reg     <= '0;
            inv_cnt_reg    <= '0;
            hold_cnt_reg   <= '0;
            block_lock_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sh_cnt_reg     <= sh_cnt_next;
            inv_cnt_reg    <= inv_cnt_next;
            hold_cnt_reg   <= hold_cnt_next;
            block_lock_reg <= block_lock_next;
        end
    end

    // A pending output survives loss of lock and drains; only reset discards it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (m_axis_tready) begin
                out_valid_reg <= 1'b0;
            end
            if (checking) begin
                out_data_reg  <= s_axis_tdata;
                out_valid_reg <= block_lock_reg && !hi_ber;
            end
        end
    end

`ifdef BLOCK_LOCK_HIBER_EN
    hi_ber_mon u_hi_ber_mon (
        .clk         (clk),
        .reset       (reset),
        .hdr_strobe  (checking),
        .hdr_invalid (!sh_valid),
        .hi_ber      (hi_ber)
    );
`else
    assign hi_ber = 1'b0;
`endif

    assign m_axis_tdata  = out_data_reg;
    assign m_axis_tvalid = out_valid_reg;
    assign slip          = (state_reg == SLIP);
    assign block_lock    = block_lock_reg;

endmodule
